rom_fetch: RTL

- Sequential word-fetch front end for the 256x32 synchronous ROM (rom256).
- Drives the ROM's addr from an internal program counter and captures rdata, which arrives one cycle later.
- Buffers fetched words in a small FIFO and presents them downstream with a valid/ready handshake, tagged with their address.
- Sits between the ROM and the future RISC-V decode stage; also usable to step ROM contents onto the LEDs.

---
 rtl/rom_fetch_pkg.sv | 25 ++
 rtl/rom_fetch_fifo.sv | 65 ++++++
 rtl/rom_fetch.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rom_fetch_pkg.sv
// -----------------------------------------------------------------------------
// rom_fetch_pkg
// Shared definitions for the rom_fetch word-fetch front end:
//   ROM_ADDR_W / ROM_DATA_W  default widths matching the 256x32 rom256
//   FETCH_DEPTH              default output FIFO depth
//   fetch_entry_t            default FIFO entry {pc, data}
//   ptr_width()              log2 helper used to size FIFO pointers/counts
// -----------------------------------------------------------------------------
package rom_fetch_pkg;

  localparam int ROM_ADDR_W  = 8;
  localparam int ROM_DATA_W  = 32;
  localparam int FETCH_DEPTH = 2;

  typedef struct packed {
    logic [ROM_ADDR_W-1:0] pc;
    logic [ROM_DATA_W-1:0] data;
  } fetch_entry_t;

  // Pointer width for a power-of-two depth; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rom_fetch_fifo.sv
// -----------------------------------------------------------------------------
// rom_fetch_fifo
// Small synchronous FIFO holding fetched {pc, data} entries.
//   clk, resetn   clock, asynchronous active-low reset (resets to empty)
//   flush         synchronous clear; wins over push and pop
//   push, wdata   write wdata at the tail
//   pop           drop the head (ignored when empty)
//   rdata         head entry; all-zero while empty
//   count         number of valid entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module rom_fetch_fifo
  import rom_fetch_pkg::*;
#(
  parameter int  DEPTH   = FETCH_DEPTH,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W   = ptr_width(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  entry_t           wdata,
  output entry_t           rdata,
  output logic [CNT_W-1:0] count
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  // NOTE: the storage array is deliberately not reset; count and the pointers
  // alone decide which entries are meaningful, and the head is masked below.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assert property (@(posedge clk) disable iff (!resetn)
    !(push && !flush && !do_pop && (count == CNT_W'(DEPTH))));

  assign rdata = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/rom_fetch.sv
// -----------------------------------------------------------------------------
// rom_fetch
// Sequential word-fetch front end for the 256x32 synchronous rom256. Drives the
// ROM address from a program counter, captures the word one cycle later and
// queues {pc, word} for a valid/ready consumer.
//   clk, resetn        clock, asynchronous active-low reset
//   step               (ROM_FETCH_STEP_EN only) pushbutton; each rising edge
//                      allows exactly one fetch
//   fetch_en           allow new fetches; in-flight data still lands when low
//   redirect_valid/pc  load a new pc and flush everything in flight
//   mem_addr           to rom256 addr (the pc register)
//   mem_rdata          from rom256 rdata, one cycle after the address
//   instr_valid/ready  output handshake
//   instr_data/pc      head word and the address it was read from
// Optional build macro: ROM_FETCH_STEP_EN (adds the step port).
// -----------------------------------------------------------------------------
module rom_fetch
  import rom_fetch_pkg::*;
#(
  parameter int                ADDR_W   = ROM_ADDR_W,
  parameter int                DATA_W   = ROM_DATA_W,
  parameter int                DEPTH    = FETCH_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              resetn,
`ifdef ROM_FETCH_STEP_EN
  input  logic              step,
`endif
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int CNT_W = ptr_width(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occupancy;
  logic [CNT_W:0]    limit;
  logic              credit_ok;
  logic              issue_gate;
  logic              issue;
  logic              push;
  logic              pop;
  entry_t            wr_entry;
  entry_t            head;

  assign pop  = instr_valid & instr_ready;
  assign push = inflight & ~redirect_valid;

  // Slots already claimed (queued + in flight) must stay within DEPTH after the
  // edge. The slot freed by this cycle's pop counts as available, which keeps
  // one word per cycle flowing while the consumer is ready.
  assign occupancy = {1'b0, fifo_count} + (CNT_W+1)'(inflight);
  assign limit     = (CNT_W+1)'(DEPTH) + (CNT_W+1)'(pop);
  assign credit_ok = occupancy < limit;

`ifdef ROM_FETCH_STEP_EN
  logic step_q;
  logic step_credit;

  // One credit per rising edge of step, consumed by the issue it enables.
  // A new edge on the consuming cycle re-arms it; it never exceeds one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      step_q      <= 1'b0;
      step_credit <= 1'b0;
    end else begin
      step_q      <= step;
      step_credit <= (step_credit & ~issue) | (step & ~step_q);
    end
  end

  assign issue_gate = step_credit;
`else
  assign issue_gate = 1'b1;
`endif

  assign issue = fetch_en & ~redirect_valid & credit_ok & issue_gate;

  // NOTE: all sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + 1'b1;
      end
    end
  end

  assign wr_entry = '{pc: inflight_pc, data: mem_rdata};

  rom_fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .flush  (redirect_valid),
    .push   (push),
    .pop    (pop),
    .wdata  (wr_entry),
    .rdata  (head),
    .count  (fifo_count)
  );

  assign mem_addr    = pc;
  assign instr_valid = (fifo_count != '0);
  assign instr_data  = head.data;
  assign instr_pc    = head.pc;

endmodule
